// File: rtl/hq2x_pkg.sv
// Shared types and constants for the hq2x pixel scheduler.
//   state_t      : input-side scheduler states
//   CE_PER_PIX   : scaler clock enables issued per input pixel
//   FLUSH_PIX    : dummy pixels pushed at end of line
//   LINE_CNT_W   : width of the completed-line counter
package hq2x_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2,
        ST_LRST  = 2'd3
    } state_t;

    localparam int unsigned CE_PER_PIX = 4;
    localparam int unsigned FLUSH_PIX  = 2;
    localparam int unsigned LINE_CNT_W = 11;

    // Sequence counter must hold the full flush length.
    localparam int unsigned FLUSH_CE   = FLUSH_PIX * CE_PER_PIX;
    localparam int unsigned SEQ_CNT_W  = 4;

    // Saturating increment of the line counter.
    function automatic logic [LINE_CNT_W-1:0] line_inc_sat(input logic [LINE_CNT_W-1:0] v);
        return (&v) ? v : v + LINE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hq2x_sched_out.sv
// Output-side row selector for the hq2x scaler.
//   clk, reset_n           : clock, async active-low reset
//   ce_out                 : output pixel strobe (qualifies all sampling)
//   hblank_out, vblank_out : output-side blanking
//   read_y                 : scaler output row select, mod 4
module hq2x_sched_out (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_out,
    input  logic       hblank_out,
    input  logic       vblank_out,
    output logic [1:0] read_y
);

    logic r_hbo_d;
    logic r_vbo_d;
    logic w_hbo_fall;
    logic w_vbo_rise;

    assign w_hbo_fall = ~hblank_out & r_hbo_d;
    assign w_vbo_rise = vblank_out & ~r_vbo_d;

    // Edge detectors only advance on ce_out; frame clear beats row advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hbo_d <= 1'b0;
            r_vbo_d <= 1'b0;
            read_y  <= 2'd0;
        end else if (ce_out) begin
            r_hbo_d <= hblank_out;
            r_vbo_d <= vblank_out;
            if (w_vbo_rise) begin
                read_y <= 2'd0;
            end else if (w_hbo_fall) begin
                read_y <= read_y + 2'd1;
            end
        end
    end

endmodule

// File: rtl/hq2x_sched.sv
// hq2x scaler input scheduler: turns each input pixel into a 4-cycle
// ce_in burst, flushes 2 dummy pixels at end of line, then pulses
// reset_line. Tracks completed lines and dropped pixels.
//   clk, reset_n             : clock, async active-low reset
//   ce_pix, din              : input pixel strobe and data
//   hblank, vblank           : input-side blanking
//   ce_in, pix               : scaler clock enable and held pixel
//   reset_line, reset_frame  : scaler line/frame sync
//   ce_out, hblank_out,
//   vblank_out, read_y       : output-side row select
//   line_cnt                 : input lines completed this frame
//   overrun                  : sticky, a pixel arrived while busy
module hq2x_sched
    import hq2x_pkg::*;
#(
    parameter int unsigned LENGTH = 768,
    parameter int unsigned DWIDTH = 23
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce_pix,
    input  logic [DWIDTH:0]       din,
    input  logic                  hblank,
    input  logic                  vblank,
    output logic                  ce_in,
    output logic [DWIDTH:0]       pix,
    output logic                  reset_line,
    output logic                  reset_frame,
    input  logic                  ce_out,
    input  logic                  hblank_out,
    input  logic                  vblank_out,
    output logic [1:0]            read_y,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic                  overrun
);

    localparam int unsigned        PCNT_W   = $clog2(LENGTH) + 1;
    localparam logic [PCNT_W-1:0]  PCNT_MAX = PCNT_W'(LENGTH);

    state_t               r_state;
    logic [SEQ_CNT_W-1:0] r_seq_cnt;
    logic [PCNT_W-1:0]    r_pix_cnt;
    logic                 r_hblank_d;
    logic                 r_vblank_d;
    logic                 r_flush_pend;

    logic w_hb_rise;
    logic w_vb_rise;
    logic w_pix_room;
    logic w_accept;
    logic w_drop;

    assign w_hb_rise  = hblank & ~r_hblank_d;
    assign w_vb_rise  = vblank & ~r_vblank_d;
    assign w_pix_room = (r_pix_cnt < PCNT_MAX);
    assign w_accept   = ce_pix & ~hblank & ~vblank & w_pix_room;
    // Pixels past the per-line limit are discarded quietly, not flagged.
    assign w_drop     = (r_state != ST_IDLE) & ce_pix & w_pix_room;

    // r_seq_cnt counts ce_in pulses still to issue in the current state,
    // so the last burst edge can chain straight into the flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_seq_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_hblank_d   <= 1'b0;
            r_vblank_d   <= 1'b0;
            r_flush_pend <= 1'b0;
            ce_in        <= 1'b0;
            pix          <= '0;
            reset_line   <= 1'b0;
            reset_frame  <= 1'b1;
            line_cnt     <= '0;
            overrun      <= 1'b0;
        end else begin
            r_hblank_d <= hblank;
            r_vblank_d <= vblank;

            case (r_state)
                ST_IDLE: begin
                    ce_in      <= 1'b0;
                    reset_line <= 1'b0;
                    if (w_hb_rise && (r_pix_cnt != '0)) begin
                        r_state   <= ST_FLUSH;
                        r_seq_cnt <= SEQ_CNT_W'(FLUSH_CE);
                    end else if (w_accept) begin
                        ce_in     <= 1'b1;
                        pix       <= din;
                        r_seq_cnt <= SEQ_CNT_W'(CE_PER_PIX - 1);
                        r_pix_cnt <= r_pix_cnt + PCNT_W'(1);
                        r_state   <= ST_BURST;
                    end
                end

                ST_BURST: begin
                    ce_in     <= 1'b1;
                    r_seq_cnt <= r_seq_cnt - SEQ_CNT_W'(1);
                    if (r_seq_cnt == SEQ_CNT_W'(1)) begin
                        if (r_flush_pend || w_hb_rise) begin
                            r_state      <= ST_FLUSH;
                            r_seq_cnt    <= SEQ_CNT_W'(FLUSH_CE);
                            r_flush_pend <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_hb_rise) begin
                        r_flush_pend <= 1'b1;
                    end
                end

                ST_FLUSH: begin
                    ce_in     <= 1'b1;
                    pix       <= '0;
                    r_seq_cnt <= r_seq_cnt - SEQ_CNT_W'(1);
                    if (r_seq_cnt == SEQ_CNT_W'(1)) begin
                        r_state   <= ST_LRST;
                        r_seq_cnt <= SEQ_CNT_W'(1);
                    end
                end

                ST_LRST: begin
                    // First cycle: sync pulse. Second: close the line.
                    if (r_seq_cnt != '0) begin
                        ce_in      <= 1'b1;
                        reset_line <= 1'b1;
                        r_seq_cnt  <= '0;
                    end else begin
                        ce_in       <= 1'b0;
                        reset_line  <= 1'b0;
                        line_cnt    <= line_inc_sat(line_cnt);
                        reset_frame <= vblank;
                        r_pix_cnt   <= '0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Frame start overrides the line bookkeeping above.
            if (w_vb_rise) begin
                line_cnt    <= '0;
                reset_frame <= 1'b1;
                overrun     <= 1'b0;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end
        end
    end

    hq2x_sched_out u_out (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce_out     (ce_out),
        .hblank_out (hblank_out),
        .vblank_out (vblank_out),
        .read_y     (read_y)
    );

endmodule

// File: tb/tb_hq2x_sched.sv
module tb_hq2x_sched;

    localparam int unsigned LEN = 16;
    localparam int unsigned DW  = 23;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          ce_pix = 1'b0;
    logic [DW:0]   din = '0;
    logic          hblank = 1'b0;
    logic          vblank = 1'b0;
    logic          ce_in;
    logic [DW:0]   pix;
    logic          reset_line;
    logic          reset_frame;
    logic          ce_out = 1'b0;
    logic          hblank_out = 1'b0;
    logic          vblank_out = 1'b0;
    logic [1:0]    read_y;
    logic [10:0]   line_cnt;
    logic          overrun;

    hq2x_sched #(.LENGTH(LEN), .DWIDTH(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .din         (din),
        .hblank      (hblank),
        .vblank      (vblank),
        .ce_in       (ce_in),
        .pix         (pix),
        .reset_line  (reset_line),
        .reset_frame (reset_frame),
        .ce_out      (ce_out),
        .hblank_out  (hblank_out),
        .vblank_out  (vblank_out),
        .read_y      (read_y),
        .line_cnt    (line_cnt),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: queue of future output cycles
    typedef struct {
        logic        ce;
        logic [DW:0] px;
        logic        rl;
        logic        ex;
        logic        bu;
    } ent_t;

    ent_t        q[$];
    logic        m_ce, m_rl, m_rf, m_ovr;
    logic [DW:0] m_pix;
    int          m_lc;
    logic [1:0]  m_y;
    int          line_pix;
    logic        pend, p_hb, p_vb, p_hbo, p_vbo;

    function automatic ent_t mk(input logic ce, input logic [DW:0] px,
                                input logic rl, input logic ex, input logic bu);
        ent_t e;
        e.ce = ce; e.px = px; e.rl = rl; e.ex = ex; e.bu = bu;
        return e;
    endfunction

    task automatic push_flush();
        for (int k = 0; k < 8; k++) q.push_back(mk(1'b1, '0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b1, '0, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b0));
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_ce = 0; m_rl = 0; m_rf = 1; m_ovr = 0; m_pix = '0;
            m_lc = 0; m_y = 0; line_pix = 0; pend = 0;
            p_hb = 0; p_vb = 0; p_hbo = 0; p_vbo = 0;
        end else begin
            logic hb_rise, vb_rise, drop, do_exit;
            ent_t e;
            hb_rise = hblank & ~p_hb;
            vb_rise = vblank & ~p_vb;
            drop = 0; do_exit = 0;
            if (q.size() != 0) begin
                e = q.pop_front();
                m_ce = e.ce;
                if (e.ce) m_pix = e.px;
                m_rl = e.rl;
                do_exit = e.ex;
                if (ce_pix && line_pix < LEN) drop = 1;
                if (e.bu) begin
                    if (hb_rise) pend = 1;
                    if (q.size() == 0 && pend) begin
                        push_flush();
                        pend = 0;
                    end
                end
            end else begin
                m_ce = 0; m_rl = 0;
                if (hb_rise && line_pix > 0) begin
                    push_flush();
                end else if (ce_pix && !hblank && !vblank && line_pix < LEN) begin
                    m_ce = 1; m_pix = din;
                    for (int k = 0; k < 3; k++) q.push_back(mk(1'b1, din, 1'b0, 1'b0, 1'b1));
                    line_pix++;
                end
            end
            if (do_exit) begin
                line_pix = 0;
                m_lc = (m_lc < 2047) ? m_lc + 1 : 2047;
                m_rf = vblank;
            end
            if (vb_rise) begin m_lc = 0; m_rf = 1; m_ovr = 0; end
            if (drop) m_ovr = 1;
            p_hb = hblank; p_vb = vblank;
            if (ce_out) begin
                if (vblank_out && !p_vbo) m_y = 0;
                else if (!hblank_out && p_hbo) m_y = m_y + 2'd1;
                p_hbo = hblank_out; p_vbo = vblank_out;
            end
        end
    end

    // ---------------- checking and observation (single process)
    int tests = 0;
    int fails = 0;
    int tot_ce = 0, tot_zero = 0, tot_rl = 0, tot_rl_ce = 0;
    int cur_run = 0, last_run = 0;
    logic rf_at_rl = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (ce_in) cur_run++;
        else if (cur_run != 0) begin last_run = cur_run; cur_run = 0; end
        if (ce_in && !reset_line) begin
            tot_ce++;
            if (pix == '0) tot_zero++;
        end
        if (reset_line) begin
            tot_rl++;
            if (ce_in) tot_rl_ce++;
            rf_at_rl = reset_frame;
        end
        chk("ce_in", longint'(ce_in), longint'(m_ce));
        chk("pix", longint'(pix), longint'(m_pix));
        chk("reset_line", longint'(reset_line), longint'(m_rl));
        chk("reset_frame", longint'(reset_frame), longint'(m_rf));
        chk("line_cnt", longint'(line_cnt), longint'(m_lc));
        chk("overrun", longint'(overrun), longint'(m_ovr));
        chk("read_y", longint'(read_y), longint'(m_y));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pix_in(input logic [DW:0] d);
        ce_pix = 1'b1; din = d;
        tick();
        ce_pix = 1'b0;
    endtask

    task automatic hb_pulse();
        hblank = 1'b1; ticks(4);
        hblank = 1'b0; ticks(16);
    endtask

    task automatic out_fall(input logic vb);
        ce_out = 1'b1; hblank_out = 1'b1; vblank_out = 1'b0;
        tick();
        hblank_out = 1'b0; vblank_out = vb;
        tick();
        ce_out = 1'b0;
        tick();
    endtask

    initial begin
        int s_ce, s_zero, s_rl, s_rlce;
        #1 reset_n = 1'b0;
        ticks(3);
        chk("rst ce_in", ce_in, 0);
        chk("rst pix", pix, 0);
        chk("rst reset_line", reset_line, 0);
        chk("rst reset_frame", reset_frame, 1);
        chk("rst line_cnt", line_cnt, 0);
        chk("rst overrun", overrun, 0);
        chk("rst read_y", read_y, 0);
        reset_n = 1'b1;
        ticks(3);

        // 10 pixels every 4 clk, then end of line
        s_ce = tot_ce; s_zero = tot_zero; s_rl = tot_rl; s_rlce = tot_rl_ce;
        for (int i = 0; i < 10; i++) begin
            pix_in(24'hA00000 | 24'(i + 1));
            if (i == 0) begin
                chk("latency ce_in", ce_in, 1);
                chk("latency pix", pix, 24'hA00001);
            end
            ticks(3);
        end
        hb_pulse();
        chk("A ce_in count", tot_ce - s_ce, 48);
        chk("A flush zero count", tot_zero - s_zero, 8);
        chk("A reset_line count", tot_rl - s_rl, 1);
        chk("A reset_line with ce_in", tot_rlce_diff(s_rlce), 1);
        chk("A line_cnt", line_cnt, 1);
        chk("A reset_frame at pulse", rf_at_rl, 1);
        chk("A reset_frame after", reset_frame, 0);
        chk("A overrun", overrun, 0);

        // 2-clk spacing: every second pixel dropped
        s_ce = tot_ce;
        for (int i = 0; i < 6; i++) begin
            pix_in(24'hB00000 | 24'(i + 1));
            tick();
        end
        ticks(3);
        chk("B overrun", overrun, 1);
        hb_pulse();
        chk("B ce_in count", tot_ce - s_ce, 20);
        chk("B line_cnt", line_cnt, 2);

        // hblank rises mid-burst: burst, flush and pulse back to back
        pix_in(24'hC0FFEE);
        hblank = 1'b1; ticks(4);
        hblank = 1'b0; ticks(16);
        chk("C contiguous run", last_run, 13);
        chk("C line_cnt", line_cnt, 3);
        chk("C overrun sticky", overrun, 1);

        // empty line: nothing happens
        s_ce = tot_ce; s_rl = tot_rl;
        hb_pulse();
        chk("E ce_in count", tot_ce - s_ce, 0);
        chk("E reset_line count", tot_rl - s_rl, 0);
        chk("E line_cnt", line_cnt, 3);

        // frame start
        vblank = 1'b1; ticks(3);
        chk("D line_cnt clr", line_cnt, 0);
        chk("D reset_frame", reset_frame, 1);
        chk("D overrun clr", overrun, 0);
        vblank = 1'b0; ticks(2);
        pix_in(24'h000011); ticks(3);
        pix_in(24'h000022); ticks(3);
        hb_pulse();
        chk("D reset_frame at pulse", rf_at_rl, 1);
        chk("D reset_frame after", reset_frame, 0);
        chk("D line_cnt", line_cnt, 1);

        // per-line pixel limit
        s_ce = tot_ce;
        for (int i = 0; i < 18; i++) begin
            pix_in(24'h300000 | 24'(i + 1));
            ticks(3);
        end
        hb_pulse();
        chk("F ce_in count", tot_ce - s_ce, 72);
        chk("F overrun", overrun, 0);
        chk("F line_cnt", line_cnt, 2);

        // output row select
        out_fall(1'b0); chk("G read_y 1", read_y, 1);
        out_fall(1'b0); chk("G read_y 2", read_y, 2);
        out_fall(1'b0); chk("G read_y 3", read_y, 3);
        out_fall(1'b0); chk("G read_y 0", read_y, 0);
        out_fall(1'b0); chk("G read_y 1b", read_y, 1);
        out_fall(1'b1); chk("G read_y clr", read_y, 0);
        vblank_out = 1'b0; ticks(2);

        // reset during 2nd burst cycle
        pix_in(24'h0BEEF0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("H ce_in", ce_in, 0);
        chk("H pix", pix, 0);
        chk("H reset_frame", reset_frame, 1);
        chk("H line_cnt", line_cnt, 0);
        chk("H read_y", read_y, 0);
        ticks(2);
        reset_n = 1'b1;
        s_ce = tot_ce;
        ticks(6);
        chk("H no resume", tot_ce - s_ce, 0);
        pix_in(24'h123456);
        chk("H new pix", pix, 24'h123456);
        ticks(6);
        chk("H clean burst", tot_ce - s_ce, 4);
        chk("H burst run", last_run, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic int tot_rlce_diff(input int s);
        return tot_rl_ce - s;
    endfunction

endmodule
